sqrt_job_scheduler: RTL and testbench

Round-robin scheduler that shares one `square_root_finder` core between NREQ requesters. It accepts one 16-bit operand at a time and sequences the core through a clear phase (core held in reset) and a fixed-length run phase. It then captures the 32-bit result and returns it tagged with the requester ID. It sits between the request sources and the core and is the only driver of the core's `rst` and `in`.

---
 rtl/sqrt_job_scheduler.sv | 152 +++++++++++++++
 tb/tb_sqrt_job_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_job_scheduler.sv
// sqrt_job_scheduler
//
// Round-robin scheduler that shares one square_root_finder core between
// NREQ requesters. A granted operand is latched onto core_in. The core is
// held cleared (core_run=0) for CLR_CYCLES cycles and then runs
// (core_run=1) for CORE_LAT cycles. The core output is captured on the last
// run cycle and held with the requester ID until the consumer takes it.
//
// Parameters:
//   NREQ       number of requesters (2..8)
//   CORE_LAT   cycles from core_run rising to a valid core_sqrt (>=1)
//   CLR_CYCLES cycles core_run is held low before each job (>=1)
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   req_valid  per-requester operand valid
//   req_data   operands, requester i at [16*i+15:16*i]
//   req_ready  one-hot grant, combinational, only asserted in IDLE
//   core_in    operand driven to the core
//   core_run   core reset control (0 = cleared, 1 = computing)
//   core_sqrt  core result, treated as opaque
//   res_valid  result valid
//   res_data   captured result
//   res_id     requester index of the result
//   res_ready  result consumer ready
//   job_cnt    completed-job counter (only when SQRT_SCHED_PERF_EN is defined)
//
// Optional feature macro: SQRT_SCHED_PERF_EN adds the job_cnt port/counter.

module sqrt_job_scheduler #(
    parameter int NREQ       = 4,
    parameter int CORE_LAT   = 72,
    parameter int CLR_CYCLES = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [16*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [15:0]        core_in,
    output logic               core_run,
    input  logic [31:0]        core_sqrt,
    output logic               res_valid,
    output logic [31:0]        res_data,
    output logic [2:0]         res_id,
    input  logic               res_ready
`ifdef SQRT_SCHED_PERF_EN
    ,
    output logic [15:0]        job_cnt
`endif
);

    localparam int CNT_MAX = (CORE_LAT > CLR_CYCLES) ? CORE_LAT : CLR_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        HOLD
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        ptr;

    logic              gnt_found;
    logic [2:0]        gnt_idx;
    logic [NREQ-1:0]   gnt_onehot;
    int unsigned       scan_idx;
    logic [2:0]        ptr_next;

    // Search upward from ptr with wrap-around; first valid requester wins.
    always_comb begin
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        scan_idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = ({29'b0, ptr} + k) % NREQ;
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found            = 1'b1;
                gnt_idx              = 3'(scan_idx);
                gnt_onehot[scan_idx] = 1'b1;
            end
        end
    end

    assign req_ready = (state == IDLE) ? gnt_onehot : '0;
    assign ptr_next  = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            core_run  <= 1'b0;
            core_in   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
`ifdef SQRT_SCHED_PERF_EN
            job_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        core_in <= req_data[16*gnt_idx +: 16];
                        res_id  <= gnt_idx;
                        ptr     <= ptr_next;
                        cnt     <= '0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (cnt == CW'(CLR_CYCLES - 1)) begin
                        cnt      <= '0;
                        core_run <= 1'b1;
                        state    <= RUN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    // Capture on the last run cycle while the core is still released.
                    if (cnt == CW'(CORE_LAT - 1)) begin
                        res_data  <= core_sqrt;
                        res_valid <= 1'b1;
                        core_run  <= 1'b0;
                        cnt       <= '0;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
`ifdef SQRT_SCHED_PERF_EN
                        job_cnt   <= job_cnt + 16'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_job_scheduler.sv
// tb_sqrt_job_scheduler
//
// Self-checking bench for sqrt_job_scheduler. A core stub returns
// {16'hC0DE, core_in} while core_run is high. A reference model predicts
// grants, phase timing and results; expected results go into a scoreboard
// queue that an independent monitor drains whenever res_valid is high.
// Define SQRT_SCHED_PERF_EN to also check job_cnt.

module tb_sqrt_job_scheduler;

    localparam int NREQ       = 4;
    localparam int CORE_LAT   = 72;
    localparam int CLR_CYCLES = 5;

    localparam int P_IDLE = 0;
    localparam int P_BUSY = 1;
    localparam int P_HOLD = 2;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [15:0]        core_in;
    logic               core_run;
    logic [31:0]        core_sqrt;
    logic               res_valid;
    logic [31:0]        res_data;
    logic [2:0]         res_id;
    logic               res_ready;
`ifdef SQRT_SCHED_PERF_EN
    logic [15:0]        job_cnt;
`endif

    sqrt_job_scheduler #(
        .NREQ       (NREQ),
        .CORE_LAT   (CORE_LAT),
        .CLR_CYCLES (CLR_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .core_in   (core_in),
        .core_run  (core_run),
        .core_sqrt (core_sqrt),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
`ifdef SQRT_SCHED_PERF_EN
        ,
        .job_cnt   (job_cnt)
`endif
    );

    assign core_sqrt = core_run ? {16'hC0DE, core_in} : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic            started = 1'b0;
    int              m_phase = P_IDLE;
    int              m_ptr   = 0;
    int              m_j     = 0;
    int              m_hc    = 0;
    int              m_jobs  = 0;
    logic [15:0]     m_op    = '0;
    logic [NREQ-1:0] m_gnt   = '0;
    logic [34:0]     sb[$];

    // Predictor: per-cycle expectations from the round-robin/phase rules.
    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        logic            found;
        logic            er;
        logic            ev;
        int              gi;
        int              idx;
        eg = '0; found = 1'b0; er = 1'b0; ev = 1'b0; gi = 0; idx = 0;
        case (m_phase)
            P_IDLE: begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        gi    = idx;
                    end
                end
                if (found) eg[gi] = 1'b1;
            end
            P_BUSY: er = (m_j > CLR_CYCLES);
            default: ev = 1'b1;
        endcase
        if (started) begin
            chk("req_ready", 64'(req_ready), 64'(eg));
            chk("core_run", 64'(core_run), 64'(er));
            chk("res_valid", 64'(res_valid), 64'(ev));
            chk("core_in", 64'(core_in), 64'(m_op));
`ifdef SQRT_SCHED_PERF_EN
            chk("job_cnt", 64'(job_cnt), 64'(m_jobs));
`endif
        end
        m_gnt = '0;
        if (rst) begin
            m_phase = P_IDLE; m_ptr = 0; m_j = 0; m_hc = 0; m_jobs = 0; m_op = '0;
            sb.delete();
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (found) begin
                        m_gnt   = eg;
                        m_op    = req_data[16*gi +: 16];
                        sb.push_back({3'(gi), 16'hC0DE, m_op});
                        m_ptr   = (gi + 1) % NREQ;
                        m_phase = P_BUSY;
                        m_j     = 1;
                    end
                end
                P_BUSY: begin
                    if (m_j == CLR_CYCLES + CORE_LAT) begin
                        m_phase = P_HOLD;
                        m_hc    = 0;
                    end else begin
                        m_j++;
                    end
                end
                default: begin
                    m_hc++;
                    if (res_ready) begin
                        m_phase = P_IDLE;
                        m_jobs  = (m_jobs + 1) % 65536;
                    end
                end
            endcase
        end
    end

    // Monitor: compares presented results against the scoreboard head.
    always @(negedge clk) begin
        if (started && res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL result_unexpected: actual id=%0d data=%0h required none @%0t",
                         res_id, res_data, $time);
            end else begin
                chk("res_id", 64'(res_id), 64'(sb[0][34:32]));
                chk("res_data", 64'(res_data), 64'(sb[0][31:0]));
                if (res_ready) void'(sb.pop_front());
            end
        end
    end

    // Driver
    logic [NREQ-1:0] pend    = '0;
    logic [NREQ-1:0] persist = '0;
    int              rr_mode = 0;

    task automatic cycle();
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++)
            if (m_gnt[i] && !persist[i]) pend[i] = 1'b0;
        req_valid = pend;
        case (rr_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = ($urandom_range(0, 3) != 0);
            default: res_ready = !(m_phase == P_HOLD && m_hc < 10);
        endcase
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset(input int n);
        pend = '0; persist = '0;
        rst  = 1'b1;
        run(n);
        rst  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b1;
        run(3);
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);
        chk("reset_res_data", 64'(res_data), 64'h0);
        chk("reset_res_id", 64'(res_id), 64'h0);

        // Single request on requester 0
        req_data[15:0] = 16'd3; pend[0] = 1'b1;
        run(90);

        // All four requesters at once after reset
        do_reset(1);
        req_data = {16'd15, 16'd11, 16'd7, 16'd3};
        pend = 4'b1111;
        run(4 * (CLR_CYCLES + CORE_LAT + 2) + 10);

        // Requesters 0 and 2 held valid permanently
        req_data[15:0] = 16'h0100; req_data[47:32] = 16'h0200;
        persist = 4'b0101; pend = 4'b0101;
        run(4 * (CLR_CYCLES + CORE_LAT + 2) + 5);
        persist = '0; pend = '0;
        run(90);

        // Backpressure: 10 cycles of res_ready low, another requester waiting
        rr_mode = 2;
        req_data[31:16] = 16'h1234; pend[1] = 1'b1;
        run(10);
        req_data[63:48] = 16'h5678; pend[3] = 1'b1;
        run(2 * (CLR_CYCLES + CORE_LAT + 12) + 10);
        rr_mode = 0;

        // Reset during RUN cycle 30, then a job on requester 1
        req_data[15:0] = 16'hBEEF; pend[0] = 1'b1;
        begin
            int n;
            for (n = 0; n < 300 && !(m_phase == P_BUSY && m_j == CLR_CYCLES + 30); n++) cycle();
            chk("reach_run30", 64'(m_phase == P_BUSY && m_j == CLR_CYCLES + 30), 64'h1);
        end
        do_reset(1);
        @(negedge clk);
        chk("midrun_res_data", 64'(res_data), 64'h0);
        chk("midrun_res_id", 64'(res_id), 64'h0);
        req_data[31:16] = 16'h00A5; pend[1] = 1'b1;
        run(CLR_CYCLES + CORE_LAT + 10);

        // Randomized traffic with random backpressure and occasional drops
        rr_mode = 1;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 39) == 0) begin
                    req_data[16*i +: 16] = 16'($urandom);
                    pend[i] = 1'b1;
                end else if (pend[i] && $urandom_range(0, 199) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            cycle();
        end

        // Drain
        pend = '0; rr_mode = 0;
        run(CLR_CYCLES + CORE_LAT + 20);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
